// File: rtl/lc3_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC-3 memory access sequencer:
//   - DATA_W          : SRAM / CPU data word width
//   - IO_ADDR_DEFAULT : default memory-mapped I/O word address
//   - mem_state_t     : sequencer FSM state encoding
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

    localparam int          DATA_W          = 16;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ACT   = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        IO       = 3'd5,
        DONE     = 3'd6
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_seq.sv
// ---------------------------------------------------------------------------
// lc3_mem_seq
// Turns the LC-3 control unit's level-sensitive active-low memory strobes
// into phased SRAM read/write cycles with WAIT_STATES extra active cycles,
// and decodes the memory-mapped I/O word (switches in, hex display out).
//
// Optional feature macro: LC3_MEM_HEX_IO_EN
//   defined   : accesses to IO_ADDR go to Switches / HEX_Data, no SRAM cycle
//   undefined : IO_ADDR is ordinary SRAM and HEX_Data is tied to 0
//
// Ports
//   Clk, Reset                : clock, asynchronous active-low reset
//   Mem_CE, Mem_OE, Mem_WE    : active-low request strobes from control unit
//   MAR, MDR_out              : access address and write data
//   Switches                  : board switches, read at IO_ADDR
//   SRAM_DQ_in                : data returned by the SRAM
//   Data_to_CPU               : registered read data for the MDR mux
//   Mem_Ready                 : one-cycle completion pulse
//   SRAM_ADDR                 : zero-extended latched MAR
//   SRAM_DQ_out, SRAM_DQ_oe   : write data and pad drive enable
//   SRAM_CE_N .. SRAM_LB_N    : active-low SRAM controls
//   HEX_Data                  : hex display register
// ---------------------------------------------------------------------------
module lc3_mem_seq
    import lc3_mem_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter int          ADDR_W      = 20,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [15:0]       MAR,
    input  logic [15:0]       MDR_out,
    input  logic [15:0]       Switches,
    input  logic [15:0]       SRAM_DQ_in,
    output logic [15:0]       Data_to_CPU,
    output logic              Mem_Ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [15:0]       SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [15:0]       HEX_Data
);

    localparam int              CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic [15:0]       data_q, data_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ready_q, ready_d;
    logic              in_done_q, in_done_d;
    logic              req_s;
`ifdef LC3_MEM_HEX_IO_EN
    logic [15:0]       hex_q, hex_d;
`endif

    // Next-state and datapath: latch the request in IDLE, time the access phases
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        data_d   = data_q;
`ifdef LC3_MEM_HEX_IO_EN
        hex_d    = hex_q;
`endif
        req_s    = (~Mem_CE) & ((~Mem_OE) | (~Mem_WE));

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    // Both strobes low counts as a write.
                    wr_d     = ~Mem_WE;
                    addr_d   = ADDR_W'(MAR);
                    dq_out_d = MDR_out;
`ifdef LC3_MEM_HEX_IO_EN
                    if (MAR == IO_ADDR) begin
                        state_d = IO;
                    end else if (!Mem_WE) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_ACT;
                        cnt_d   = CNT_LOAD;
                    end
`else
                    if (!Mem_WE) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_ACT;
                        cnt_d   = CNT_LOAD;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ACT: begin
                // Counter stops at zero; the zero cycle is the last active one.
                if (cnt_q == '0) begin
                    data_d  = SRAM_DQ_in;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CNT_LOAD;
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_d = DONE;
            end
`ifdef LC3_MEM_HEX_IO_EN
            IO: begin
                if (wr_q) begin
                    hex_d = dq_out_q;
                end else begin
                    data_d = Switches;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                // Hold here until the control unit drops its strobes so a
                // long-held strobe yields a single access.
                if (Mem_OE && Mem_WE) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin controls follow the state being entered so they line up with it
    always_comb begin
        ce_n_d    = ~(state_d inside {RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD});
        oe_n_d    = (state_d != RD_ACT);
        we_n_d    = (state_d != WR_PULSE);
        dq_oe_d   = (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
        in_done_d = (state_q == DONE);
        // Pulse only on the first DONE cycle, however long DONE lasts.
        ready_d   = (state_q == DONE) & ~in_done_q;
    end

    // State, datapath and registered pin outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dq_out_q  <= 16'h0000;
            data_q    <= 16'h0000;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
            ready_q   <= 1'b0;
            in_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            data_q    <= data_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dq_oe_q   <= dq_oe_d;
            ready_q   <= ready_d;
            in_done_q <= in_done_d;
        end
    end

`ifdef LC3_MEM_HEX_IO_EN
    // Hex display register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hex_q <= 16'h0000;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign HEX_Data = hex_q;
`else
    logic unused_s;
    assign unused_s = ^{Switches, IO_ADDR, wr_q};
    assign HEX_Data = 16'h0000;
`endif

    assign Data_to_CPU = data_q;
    assign Mem_Ready   = ready_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = dq_out_q;
    assign SRAM_DQ_oe  = dq_oe_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;

endmodule
